sp3a_bw32to16: RTL
==================

Name: sp3a_bw32to16

Overview:
- Upstream adapter that turns a 32-bit master access into one or two 16-bit transactions on the 16-bit ix bus, which the clock-crossing bridge then carries.
- Sits between a 32-bit master (CPU or DMA) and the ix port. Both sides run on ix_clk.
- Handles byte-enable based half skipping, read data assembly, and the completion handshake back to the master.

Parameters:
- HI_FIRST, 0, 1 = issue the high halfword (addr|2) before the low halfword (addr&~3); 0 = low first.
- SKIP_EMPTY, 1, 1 = omit any half whose byte enables are all 0; 0 = always issue both halves.
- TMO_W, 8, width of the watchdog counter. Used only with SP3A_BW32_TMO_EN.

Ports:
- ix_clk  in  1  clock
- ix_rst_n  in  1  asynchronous active-low reset
- m_addr  in  32  master byte address; bits [1:0] ignored
- m_wdata  in  32  master write data
- m_be  in  4  master byte enables
- m_rd  in  1  1 = read, 0 = write
- m_req  in  1  request; sampled only while m_busy=0
- m_busy  out  1  adapter busy
- m_ack  out  1  one-cycle completion pulse
- m_rdata  out  32  assembled read data, held after m_ack
- m_err  out  1  registered copy of ix_err
- ix_addr  out  32  halfword address
- ix_wdata  out  16  halfword write data
- ix_be  out  2  halfword byte enables
- ix_rd  out  1  read/#write
- ix_req  out  1  one-cycle request pulse
- ix_rdata  in  16  read data, valid while ix_ack=1 on reads
- ix_busy  in  1  downstream busy
- ix_ack  in  1  downstream ack. Writes: same cycle as ix_req. Reads: later pulse while busy.
- ix_err  in  1  downstream error level

Behaviour:
- Clock, reset and general:
  - Clock ix_clk; reset ix_rst_n, asynchronous, active-low.
  - Reset values: all outputs 0, state IDLE, capture registers 0.
  - All outputs are registered except ix_req, which is state-decoded (see ISSUE).
- Halves:
  - L = {addr[31:2],2'b00}, be[1:0], wdata[15:0], rdata[15:0].
  - H = {addr[31:2],2'b10}, be[3:2], wdata[31:16], rdata[31:16].
  - Order is set by HI_FIRST.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE:
  - m_busy=0.
  - On m_req=1: latch addr, wdata, be, rd; m_busy=1 from the next cycle.
  - Next state: ISSUE1. If SKIP_EMPTY=1 and the first half is empty, go to ISSUE2 instead. If both halves are empty, go to DONE.
- ISSUEn:
  - ix_addr, ix_be, ix_wdata, ix_rd are driven from the latched half.
  - ix_req=1 only in a cycle where ix_busy=0; otherwise stay in ISSUEn.
  - Write: ix_ack sampled 1 in the ix_req cycle completes the half. Go to the next half, or DONE.
  - Write with ix_ack=0 in the ix_req cycle: go to WAITn.
  - Read: always go to WAITn.
- WAITn:
  - On ix_ack=1: for reads, capture ix_rdata into the matching m_rdata half.
  - Then go to the next half, or DONE.
  - The next ISSUE waits for ix_busy=0.
- DONE:
  - m_ack=1 for exactly one cycle, m_busy=1.
  - Next state: IDLE (m_busy=0 on the following cycle).
  - A new m_req is accepted no earlier than the first IDLE cycle.
- m_rdata:
  - Halves not read keep their prior value.
  - Written only by reads.
- Latency:
  - Best case, write of both halves with immediate acks: m_req at cycle 0, ix_req at cycles 1 and 2, m_ack at cycle 3.
  - Reads add downstream latency per half.
- Empty access (m_be=0, SKIP_EMPTY=1): no ix_req; m_ack at cycle 2.
- m_err: ix_err registered one cycle. No effect on the state machine.
- ix_ack in IDLE or DONE: ignored.
- Reset mid-transaction: immediate return to IDLE and reset values; the latched request is discarded.

Optional Feature:
- Macro: SP3A_BW32_TMO_EN.
- When defined:
  - A TMO_W-bit counter clears on each state change and increments in ISSUEn and WAITn.
  - On all-ones it forces DONE: m_ack pulses and the sticky output m_tmo (1 bit, reset 0, cleared on next accepted m_req) is set.
  - Read halves not completed return 16'hFFFF in m_rdata.
  - The next accepted request waits in ISSUE1 until ix_busy=0.
- When undefined: no counter, no m_tmo port; ISSUE and WAIT wait indefinitely.

Test Plan:
- Write m_addr=32'h1000_0006, m_wdata=32'hA1B2_C3D4, m_be=4'hF, immediate acks -> ix_req at 1000_0004 (be 2'b11, data C3D4) then 1000_0006 (data A1B2); m_ack at cycle 3.
- Read 32'h2000_0000, be F; downstream acks each half 4 cycles after ix_req with 16'h5678 then 16'h1234 -> m_rdata=32'h1234_5678 with m_ack; m_busy is 0 the next cycle.
- m_be=4'b1100, SKIP_EMPTY=1, write -> single ix_req at addr|2, be 2'b11; with SKIP_EMPTY=0 -> two ix_req, first with be 2'b00.
- m_be=4'h0 -> no ix_req; m_ack 2 cycles after m_req.
- ix_busy held 1 for 10 cycles at ISSUE1 -> ix_req withheld, then issued in the first cycle ix_busy=0; m_req pulses during m_busy=1 are ignored.
- Reset asserted in WAIT2 -> all outputs 0 asynchronously; after release, a new write completes normally. With SP3A_BW32_TMO_EN and TMO_W=4, a read that is never acked -> m_ack after 15 cycles in WAIT, m_tmo=1, m_rdata half = FFFF.

Source files
------------

// File: rtl/sp3a_bw32to16.sv
// 32-to-16 bit bus adapter: splits a master access into one or two ix halfword transactions.
// Optional watchdog timeout (adds TMO_W and m_tmo) is enabled with `define SP3A_BW32_TMO_EN.
module sp3a_bw32to16 #(
  parameter int HI_FIRST   = 0,
  parameter int SKIP_EMPTY = 1
`ifdef SP3A_BW32_TMO_EN
  , parameter int TMO_W    = 8
`endif
) (
  input  logic        ix_clk,
  input  logic        ix_rst_n,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_be,
  input  logic        m_rd,
  input  logic        m_req,
  output logic        m_busy,
  output logic        m_ack,
  output logic [31:0] m_rdata,
  output logic        m_err,
`ifdef SP3A_BW32_TMO_EN
  output logic        m_tmo,
`endif
  output logic [31:0] ix_addr,
  output logic [15:0] ix_wdata,
  output logic [1:0]  ix_be,
  output logic        ix_rd,
  output logic        ix_req,
  input  logic [15:0] ix_rdata,
  input  logic        ix_busy,
  input  logic        ix_ack,
  input  logic        ix_err
);

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;

  localparam logic FIRST_HI = (HI_FIRST != 0);
  localparam logic SKIP     = (SKIP_EMPTY != 0);

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        m_busy_q, m_busy_d, m_ack_q, m_ack_d, m_err_q, m_err_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [31:0] ix_addr_q, ix_addr_d;
  logic [15:0] ix_wdata_q, ix_wdata_d;
  logic [1:0]  ix_be_q, ix_be_d;
  logic        ix_rd_q, ix_rd_d;

  logic [29:0] src_addr;
  logic [31:0] src_wdata;
  logic [3:0]  src_be;
  logic        src_rd;
  logic        first_skip, second_skip, both_skip, load_hi;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^m_addr[1:0];

`ifdef SP3A_BW32_TMO_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             m_tmo_q, m_tmo_d, in_xfer;
`endif

  // In IDLE the halves are judged from the live request, afterwards from the latched copy
  always_comb begin
    src_addr    = (state_q == IDLE) ? m_addr[31:2] : addr_q;
    src_wdata   = (state_q == IDLE) ? m_wdata : wdata_q;
    src_be      = (state_q == IDLE) ? m_be : be_q;
    src_rd      = (state_q == IDLE) ? m_rd : rd_q;
    first_skip  = SKIP && ((FIRST_HI ? src_be[3:2] : src_be[1:0]) == 2'b00);
    second_skip = SKIP && ((FIRST_HI ? src_be[1:0] : src_be[3:2]) == 2'b00);
    both_skip   = first_skip && second_skip;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    m_rdata_d  = m_rdata_q;
    m_err_d    = ix_err;
    ix_addr_d  = ix_addr_q;
    ix_wdata_d = ix_wdata_q;
    ix_be_d    = ix_be_q;
    ix_rd_d    = ix_rd_q;
    ix_req     = 1'b0;
    load_hi    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr[31:2];
          wdata_d = m_wdata;
          be_d    = m_be;
          rd_d    = m_rd;
          state_d = (first_skip && !second_skip) ? ISSUE2 : ISSUE1;
        end
      end
      // An all-empty access spends one silent cycle here so its ack lands two cycles after m_req
      ISSUE1: begin
        if (both_skip) begin
          state_d = DONE;
        end else if (!ix_busy) begin
          ix_req = 1'b1;
          if (rd_q || !ix_ack) state_d = WAIT1;
          else                 state_d = second_skip ? DONE : ISSUE2;
        end
      end
      WAIT1: begin
        if (ix_ack) begin
          if (rd_q) begin
            if (FIRST_HI) m_rdata_d[31:16] = ix_rdata;
            else          m_rdata_d[15:0]  = ix_rdata;
          end
          state_d = second_skip ? DONE : ISSUE2;
        end
      end
      ISSUE2: begin
        if (!ix_busy) begin
          ix_req  = 1'b1;
          state_d = (rd_q || !ix_ack) ? WAIT2 : DONE;
        end
      end
      WAIT2: begin
        if (ix_ack) begin
          if (rd_q) begin
            if (FIRST_HI) m_rdata_d[15:0]  = ix_rdata;
            else          m_rdata_d[31:16] = ix_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SP3A_BW32_TMO_EN
    tmo_cnt_d = tmo_cnt_q;
    m_tmo_d   = m_tmo_q;
    in_xfer   = state_q inside {ISSUE1, WAIT1, ISSUE2, WAIT2};
    if (state_q == IDLE && m_req) m_tmo_d = 1'b0;
    // A stalled half is abandoned the moment the counter would reach all-ones
    if (in_xfer && state_d == state_q && tmo_cnt_q == {{(TMO_W-1){1'b1}}, 1'b0}) begin
      state_d = DONE;
      m_tmo_d = 1'b1;
      if (rd_q) begin
        if (state_q == ISSUE1 || state_q == WAIT1) begin
          if (FIRST_HI) m_rdata_d[31:16] = 16'hFFFF;
          else          m_rdata_d[15:0]  = 16'hFFFF;
          if (!second_skip) begin
            if (FIRST_HI) m_rdata_d[15:0]  = 16'hFFFF;
            else          m_rdata_d[31:16] = 16'hFFFF;
          end
        end else begin
          if (FIRST_HI) m_rdata_d[15:0]  = 16'hFFFF;
          else          m_rdata_d[31:16] = 16'hFFFF;
        end
      end
    end
    if (state_d != state_q) tmo_cnt_d = '0;
    else if (in_xfer)       tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
`endif

    if (state_d == ISSUE1 || state_d == ISSUE2) begin
      load_hi    = (state_d == ISSUE1) ? FIRST_HI : !FIRST_HI;
      ix_addr_d  = {src_addr, load_hi, 1'b0};
      ix_be_d    = load_hi ? src_be[3:2] : src_be[1:0];
      ix_wdata_d = load_hi ? src_wdata[31:16] : src_wdata[15:0];
      ix_rd_d    = src_rd;
    end
    m_busy_d = (state_d != IDLE);
    m_ack_d  = (state_d == DONE);
  end

  always_ff @(posedge ix_clk or negedge ix_rst_n) begin
    if (!ix_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      m_busy_q   <= 1'b0;
      m_ack_q    <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
      ix_addr_q  <= '0;
      ix_wdata_q <= '0;
      ix_be_q    <= '0;
      ix_rd_q    <= 1'b0;
`ifdef SP3A_BW32_TMO_EN
      tmo_cnt_q  <= '0;
      m_tmo_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      m_busy_q   <= m_busy_d;
      m_ack_q    <= m_ack_d;
      m_err_q    <= m_err_d;
      m_rdata_q  <= m_rdata_d;
      ix_addr_q  <= ix_addr_d;
      ix_wdata_q <= ix_wdata_d;
      ix_be_q    <= ix_be_d;
      ix_rd_q    <= ix_rd_d;
`ifdef SP3A_BW32_TMO_EN
      tmo_cnt_q  <= tmo_cnt_d;
      m_tmo_q    <= m_tmo_d;
`endif
    end
  end

  assign m_busy   = m_busy_q;
  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;
  assign m_rdata  = m_rdata_q;
  assign ix_addr  = ix_addr_q;
  assign ix_wdata = ix_wdata_q;
  assign ix_be    = ix_be_q;
  assign ix_rd    = ix_rd_q;
`ifdef SP3A_BW32_TMO_EN
  assign m_tmo    = m_tmo_q;
`endif

endmodule
